hall_sensor_decoder: RTL and testbench

//   Conditions raw 3-bit hall inputs before the BLDC commutation peripheral: 2-FF synchronizer, glitch filter,

---
 rtl/hall_sensor_decoder.sv | 190 +++++++++++++++++++
 tb/tb_hall_sensor_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hall_sensor_decoder.sv
// Hall input conditioning for BLDC commutation: synchronizer, glitch filter, sector decode,
// direction detection, commutation-period measurement and stall/fault flags.
module hall_sensor_decoder #(
  parameter int clk_freq_hz          = 54_000_000,
  parameter int filter_cycles        = 54,
  parameter int period_width         = 24,
  parameter int stall_timeout_cycles = 5_400_000
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic [2:0]              hall_in,
  input  logic                    fault_clear,
  output logic [2:0]              sector,
  output logic                    sector_valid,
  output logic                    commutation_stb,
  output logic [1:0]              dir,
  output logic [period_width-1:0] period,
  output logic                    period_valid,
  output logic                    stalled,
  output logic                    hall_fault,
  output logic                    step_err
);

  localparam int fcw = (filter_cycles > 1) ? $clog2(filter_cycles) : 1;
  localparam logic [fcw-1:0]          filt_max  = fcw'(filter_cycles - 1);
  localparam logic [period_width-1:0] cnt_max   = '1;
  localparam logic [period_width-1:0] stall_tmo = period_width'(stall_timeout_cycles);

  localparam logic [1:0] dir_unknown = 2'b00;
  localparam logic [1:0] dir_fwd     = 2'b01;
  localparam logic [1:0] dir_rev     = 2'b10;

  if (filter_cycles < 1 || clk_freq_hz < 1 ||
      longint'(stall_timeout_cycles) >= (longint'(1) << period_width)) begin : g_param_check
    $error("hall_sensor_decoder: illegal parameter combination");
  end

  logic [2:0]     sync1, sync2, cand, filt;
  logic [fcw-1:0] fcnt;
  logic           accept;

  always_ff @(posedge pclk) begin
    if (prst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      filt  <= '0;
      fcnt  <= '0;
    end else begin
      sync1 <= hall_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        fcnt <= '0;
      end else if (fcnt != filt_max) begin
        fcnt <= fcnt + fcw'(1);
      end
      if (accept) filt <= cand;
    end
  end

  // The filter acceptance cycle is also the decode cycle, so outputs land with filt.
  assign accept = (fcnt == filt_max) && (cand != filt);

  function automatic logic is_legal(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  function automatic logic [2:0] to_sector(input logic [2:0] code);
    logic [2:0] s;
    s = 3'd0;
    case (code)
      3'b001:  s = 3'd0;
      3'b011:  s = 3'd1;
      3'b010:  s = 3'd2;
      3'b110:  s = 3'd3;
      3'b100:  s = 3'd4;
      3'b101:  s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  logic       new_legal, old_legal;
  logic [2:0] new_sec;
  logic [3:0] delta_raw;
  logic [2:0] delta;

  assign new_legal = is_legal(cand);
  assign old_legal = is_legal(filt);
  assign new_sec   = to_sector(cand);
  assign delta_raw = {1'b0, new_sec} + 4'd6 - {1'b0, sector};
  assign delta     = (delta_raw >= 4'd6) ? 3'(delta_raw - 4'd6) : delta_raw[2:0];

  // running: edge counter active (a legal code seen since reset/fault).
  // ref_ok: the last edge is a usable start point for a period measurement.
  logic [period_width-1:0] ecnt, ecnt_nxt, period_nxt;
  logic                    running, running_nxt, ref_ok, ref_ok_nxt;
  logic [2:0]              sector_nxt;
  logic [1:0]              dir_nxt;
  logic                    valid_nxt, stb_nxt, pv_nxt, stalled_nxt, fault_nxt, serr_nxt;

  always_comb begin
    sector_nxt  = sector;
    valid_nxt   = sector_valid;
    stb_nxt     = 1'b0;
    dir_nxt     = dir;
    period_nxt  = period;
    pv_nxt      = period_valid;
    stalled_nxt = stalled;
    fault_nxt   = hall_fault & ~fault_clear;
    serr_nxt    = step_err & ~fault_clear;
    ecnt_nxt    = ecnt;
    running_nxt = running;
    ref_ok_nxt  = ref_ok;

    if (running && ecnt != cnt_max) ecnt_nxt = ecnt + period_width'(1);

    if (running && ecnt == stall_tmo) begin
      stalled_nxt = 1'b1;
      dir_nxt     = dir_unknown;
      pv_nxt      = 1'b0;
      ref_ok_nxt  = 1'b0;
    end

    if (accept) begin
      if (!new_legal) begin
        valid_nxt   = 1'b0;
        fault_nxt   = 1'b1;
        dir_nxt     = dir_unknown;
        pv_nxt      = 1'b0;
        running_nxt = 1'b0;
        ref_ok_nxt  = 1'b0;
        ecnt_nxt    = '0;
      end else begin
        sector_nxt  = new_sec;
        valid_nxt   = 1'b1;
        stb_nxt     = 1'b1;
        stalled_nxt = 1'b0;
        running_nxt = 1'b1;
        ref_ok_nxt  = 1'b1;
        ecnt_nxt    = period_width'(1);
        if (old_legal) begin
          if (delta == 3'd1 || delta == 3'd5) begin
            dir_nxt = (delta == 3'd1) ? dir_fwd : dir_rev;
            if (ref_ok && !stalled) begin
              period_nxt = ecnt;
              pv_nxt     = 1'b1;
            end
          end else begin
            serr_nxt = 1'b1;
            dir_nxt  = dir_unknown;
            pv_nxt   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      sector          <= '0;
      sector_valid    <= 1'b0;
      commutation_stb <= 1'b0;
      dir             <= dir_unknown;
      period          <= '0;
      period_valid    <= 1'b0;
      stalled         <= 1'b1;
      hall_fault      <= 1'b0;
      step_err        <= 1'b0;
      ecnt            <= '0;
      running         <= 1'b0;
      ref_ok          <= 1'b0;
    end else begin
      sector          <= sector_nxt;
      sector_valid    <= valid_nxt;
      commutation_stb <= stb_nxt;
      dir             <= dir_nxt;
      period          <= period_nxt;
      period_valid    <= pv_nxt;
      stalled         <= stalled_nxt;
      hall_fault      <= fault_nxt;
      step_err        <= serr_nxt;
      ecnt            <= ecnt_nxt;
      running         <= running_nxt;
      ref_ok          <= ref_ok_nxt;
    end
  end

endmodule

// File: tb/tb_hall_sensor_decoder.sv
// Directed bench for hall_sensor_decoder: expected states are queued when a step is driven
// and popped/compared when the decoded result is due.
module tb_hall_sensor_decoder;

  localparam int F  = 54;
  localparam int PW = 24;
  localparam int T  = 3000;
  localparam int LAT = F + 3;

  logic          pclk = 1'b0;
  logic          prst, fault_clear;
  logic [2:0]    hall_in;
  logic [2:0]    sector;
  logic          sector_valid, commutation_stb, period_valid, stalled, hall_fault, step_err;
  logic [1:0]    dir;
  logic [PW-1:0] period;

  hall_sensor_decoder #(
    .clk_freq_hz(54_000_000), .filter_cycles(F), .period_width(PW), .stall_timeout_cycles(T)
  ) dut (
    .pclk(pclk), .prst(prst), .hall_in(hall_in), .fault_clear(fault_clear),
    .sector(sector), .sector_valid(sector_valid), .commutation_stb(commutation_stb),
    .dir(dir), .period(period), .period_valid(period_valid), .stalled(stalled),
    .hall_fault(hall_fault), .step_err(step_err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string         tag;
    logic          stb;
    logic [2:0]    sec;
    logic          sv;
    logic [1:0]    dir;
    logic [PW-1:0] per;
    logic          pv;
    logic          st;
    logic          hf;
    logic          se;
    logic          chk_per;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   stb_count = 0;
  int   stb_mark;

  always @(posedge pclk) if (commutation_stb === 1'b1) stb_count++;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic stb, input logic [2:0] sec,
                              input logic sv, input logic [1:0] d, input int per, input logic pv,
                              input logic st, input logic hf, input logic se, input logic chk);
    exp_t e;
    e.tag = tag; e.stb = stb; e.sec = sec; e.sv = sv; e.dir = d; e.per = PW'(per);
    e.pv = pv; e.st = st; e.hf = hf; e.se = se; e.chk_per = chk;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sbq.pop_front();
    cmp({e.tag, "_stb"},     32'(commutation_stb), 32'(e.stb));
    cmp({e.tag, "_sector"},  32'(sector),          32'(e.sec));
    cmp({e.tag, "_svalid"},  32'(sector_valid),    32'(e.sv));
    cmp({e.tag, "_dir"},     32'(dir),             32'(e.dir));
    cmp({e.tag, "_stalled"}, 32'(stalled),         32'(e.st));
    cmp({e.tag, "_fault"},   32'(hall_fault),      32'(e.hf));
    cmp({e.tag, "_steperr"}, 32'(step_err),        32'(e.se));
    if (e.chk_per) begin
      cmp({e.tag, "_period"},  32'(period),       32'(e.per));
      cmp({e.tag, "_pvalid"},  32'(period_valid), 32'(e.pv));
    end
  endtask

  // Called on a negedge; returns on the negedge that follows exactly 'gap' rising edges.
  task automatic step(input logic [2:0] code, input int gap, input exp_t e);
    hall_in = code;
    sbq.push_back(e);
    repeat (LAT) @(posedge pclk);
    #1 check_pop();
    repeat (gap - LAT) @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic pulse_clear(input exp_t e);
    fault_clear = 1'b1;
    sbq.push_back(e);
    @(negedge pclk);
    fault_clear = 1'b0;
    check_pop();
  endtask

  int p_glitch;

  initial begin
    prst = 1'b1; hall_in = 3'b000; fault_clear = 1'b0;
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    sbq.push_back(mk("reset", 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1));
    check_pop();
    prst = 1'b0;

    // Never-spinning motor: stays stalled with no timeout activity.
    sbq.push_back(mk("idle", 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1));
    repeat (T + 100) @(negedge pclk);
    check_pop();

    step(3'b001, 1000, mk("first_001", 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1));
    step(3'b011, 1000, mk("fwd_011",   1, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    step(3'b010, 1000, mk("fwd_010",   1, 2, 1, 2'b01, 1000, 1, 0, 0, 0, 1));
    step(3'b110,  500, mk("fwd_110",   1, 3, 1, 2'b01, 1000, 1, 0, 0, 0, 1));
    step(3'b010,  500, mk("rev_010",   1, 2, 1, 2'b10, 500, 1, 0, 0, 0, 1));
    step(3'b011,  500, mk("rev_011",   1, 1, 1, 2'b10, 500, 1, 0, 0, 0, 1));
    step(3'b001,  500, mk("rev_001",   1, 0, 1, 2'b10, 500, 1, 0, 0, 0, 1));
    step(3'b101,  500, mk("rev_101",   1, 5, 1, 2'b10, 500, 1, 0, 0, 0, 1));
    step(3'b100,  500, mk("rev_100",   1, 4, 1, 2'b10, 500, 1, 0, 0, 0, 1));
    step(3'b110,  500, mk("rev_110",   1, 3, 1, 2'b10, 500, 1, 0, 0, 0, 1));

    // Longest pulse that must still be rejected: filter_cycles-1 cycles of 111.
    stb_mark = stb_count;
    hall_in = 3'b111;
    repeat (F - 1) @(negedge pclk);
    hall_in = 3'b110;
    sbq.push_back(mk("glitch", 0, 3, 1, 2'b10, 500, 1, 0, 0, 0, 1));
    repeat (F + 10) @(negedge pclk);
    check_pop();
    cmp("glitch_no_stb", 32'(stb_count - stb_mark), 32'd0);
    p_glitch = 500 + (F - 1) + (F + 10);

    step(3'b010, 1000, mk("rev_after_glitch", 1, 2, 1, 2'b10, p_glitch, 1, 0, 0, 0, 1));
    step(3'b111,  200, mk("fault_111", 0, 2, 0, 2'b00, p_glitch, 0, 0, 1, 0, 1));
    pulse_clear(mk("fault_clear", 0, 2, 0, 2'b00, p_glitch, 0, 0, 0, 0, 1));

    step(3'b001, 1000, mk("restart_001", 1, 0, 1, 2'b00, p_glitch, 0, 0, 0, 0, 1));
    step(3'b010, 1000, mk("jump_010",    1, 2, 1, 2'b00, p_glitch, 0, 0, 0, 1, 1));
    pulse_clear(mk("steperr_clear", 0, 2, 1, 2'b00, p_glitch, 0, 0, 0, 0, 1));

    step(3'b110, 1000, mk("spin_110", 1, 3, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    step(3'b100,  LAT, mk("spin_100", 1, 4, 1, 2'b01, 1000, 1, 0, 0, 0, 1));

    // Edge counter is 1 after the spin_100 update edge; stall lands T edges after it.
    sbq.push_back(mk("pre_stall", 0, 4, 1, 2'b01, 1000, 1, 0, 0, 0, 1));
    repeat (T - 1) @(posedge pclk);
    #1 check_pop();
    sbq.push_back(mk("stall", 0, 4, 1, 2'b00, 1000, 0, 1, 0, 0, 1));
    @(posedge pclk);
    #1 check_pop();
    repeat (100) @(negedge pclk);

    step(3'b101, 700, mk("stall_exit_101", 1, 5, 1, 2'b01, 1000, 0, 0, 0, 0, 1));
    step(3'b001, 100, mk("post_stall_001", 1, 0, 1, 2'b01, 700, 1, 0, 0, 0, 1));

    prst = 1'b1;
    hall_in = 3'b011;
    sbq.push_back(mk("reset_again", 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1));
    @(posedge pclk);
    #1 check_pop();
    prst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
